seven_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one BCD-to-seven-segment decoder. It holds a shadow copy of the digit values and walks the digit enables round-robin. Each scan slot has a fixed on-time followed by an all-off dead time to prevent ghosting. It drives the 4-bit code into the shared decoder plus the active-low anode and decimal-point lines, with optional leading-zero suppression.

---
 rtl/seven_seg_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// Walks the digit enables round-robin with an on-time per slot followed by
// an all-off dead gap, and drives the shared decoder code plus active-low
// anode and decimal-point lines. Optional leading-zero blanking.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp_out,
  output logic                    frame_tick
);

  localparam int CMAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic {DEAD, SHOW} state_t;

  state_t                         state, state_n;
  logic [CW-1:0]                  cnt, cnt_n;
  logic [IW-1:0]                  idx, idx_n;
  logic [NUM_DIGITS-1:0][3:0]     sh_dig;
  logic [NUM_DIGITS-1:0]          sh_dp;
  logic                           sh_lz;
  logic [NUM_DIGITS-1:0]          sup;
  logic                           zabove;
  logic [3:0]                     bcd_n;
  logic [NUM_DIGITS-1:0]          an_n;
  logic                           dp_n, ft_n;

  // Shadow capture is independent of scan state; the lit digit only picks
  // up new values at its next DEAD->SHOW entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_dig <= '0;
      sh_dp  <= '0;
      sh_lz  <= 1'b0;
    end else if (load) begin
      sh_dig <= digits_in;
      sh_dp  <= dp_in;
      sh_lz  <= lz_en;
    end
  end

  // Digit i>0 blanks when it and every higher digit are zero; digit 0 never.
  always_comb begin
    sup    = '0;
    zabove = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zabove = zabove & (sh_dig[i] == 4'd0);
      sup[i] = sh_lz & zabove;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DEAD;
      cnt        <= '0;
      idx        <= '0;
      bcd_out    <= 4'd0;
      an         <= '1;
      dp_out     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      bcd_out    <= bcd_n;
      an         <= an_n;
      dp_out     <= dp_n;
      frame_tick <= ft_n;
    end
  end

  // Next state and next registered outputs; enable low forces a dark restart.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    bcd_n   = bcd_out;
    an_n    = an;
    dp_n    = dp_out;
    ft_n    = 1'b0;
    if (!enable) begin
      state_n = DEAD;
      cnt_n   = '0;
      idx_n   = '0;
      an_n    = '1;
      dp_n    = 1'b1;
    end else begin
      case (state)
        DEAD: begin
          an_n = '1;
          dp_n = 1'b1;
          if (cnt == DEAD_LAST) begin
            state_n = SHOW;
            cnt_n   = '0;
            bcd_n   = sh_dig[idx];
            an_n    = sup[idx] ? '1 : ~(NUM_DIGITS'(1) << idx);
            dp_n    = sup[idx] ? 1'b1 : ~sh_dp[idx];
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_n = DEAD;
            cnt_n   = '0;
            an_n    = '1;
            dp_n    = 1'b1;
            if (idx == IDX_LAST) begin
              idx_n = '0;
              ft_n  = 1'b1;
            end else begin
              idx_n = idx + 1'b1;
            end
          end
        end
        default: state_n = DEAD;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl (4 digits, 8 on / 2 dead). Expected outputs
// for each clock edge are derived from the slot timing and pushed to a
// scoreboard; the negedge monitor pops and compares.
module tb_seven_seg_scan_ctrl;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          load;
  logic [15:0]   digits_in;
  logic [ND-1:0] dp_in;
  logic          lz_en;
  logic [3:0]    bcd_out;
  logic [ND-1:0] an;
  logic          dp_out;
  logic          frame_tick;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [3:0]    bcd;
    logic          dp;
    logic          ft;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // bench model of the shadow and of the scan position
  logic [15:0]   m_dig;
  logic [ND-1:0] m_dp;
  logic          m_lz;
  logic [3:0]    m_bcd;
  logic [ND-1:0] cur_an;
  logic          cur_dp;
  int            e;

  seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(8), .DEAD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .lz_en(lz_en), .bcd_out(bcd_out), .an(an), .dp_out(dp_out),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // monitor: outputs settle after the posedge, compare on the negedge
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("an",         8'(an),         8'(x.an));
      chk("bcd_out",    8'(bcd_out),    8'(x.bcd));
      chk("dp_out",     8'(dp_out),     8'(x.dp));
      chk("frame_tick", 8'(frame_tick), 8'(x.ft));
    end
  end

  task automatic model_reset();
    m_dig = '0; m_dp = '0; m_lz = 1'b0; m_bcd = 4'd0;
    cur_an = '1; cur_dp = 1'b1; e = 0;
  endtask

  // Scan timeline after edge e (e=1 is the first enabled edge):
  // position p=(e-1)%10, dark at p=0 and p=9, digit ((e-2)/10)%4 entered at p=1,
  // frame tick after every 40th edge.
  task automatic cycle();
    exp_t x;
    int   p, d;
    logic s;
    if (!enable) begin
      e = 0; cur_an = '1; cur_dp = 1'b1;
      x = '{an: '1, bcd: m_bcd, dp: 1'b1, ft: 1'b0};
    end else begin
      e++;
      p = (e - 1) % 10;
      if (p == 1) begin
        d      = ((e - 2) / 10) % ND;
        m_bcd  = m_dig[4*d +: 4];
        s      = m_lz && d > 0 && ((m_dig >> (4*d)) == 16'd0);
        cur_an = s ? 4'b1111 : ~(4'b0001 << d);
        cur_dp = s ? 1'b1 : ~m_dp[d];
      end else if (p == 0 || p == 9) begin
        cur_an = '1; cur_dp = 1'b1;
      end
      x = '{an: cur_an, bcd: m_bcd, dp: cur_dp, ft: (e % 40 == 0)};
    end
    if (load) begin
      m_dig = digits_in; m_dp = dp_in; m_lz = lz_en;
    end
    q.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic loadc(input logic [15:0] dig, input logic [ND-1:0] dp, input logic lz);
    digits_in = dig; dp_in = dp; lz_en = lz; load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0; lz_en = 1'b0;
    model_reset();
    #2;
    chk("rst_an",  8'(an),         8'hf);
    chk("rst_bcd", 8'(bcd_out),    8'h0);
    chk("rst_dp",  8'(dp_out),     8'h1);
    chk("rst_ft",  8'(frame_tick), 8'h0);
    @(negedge clk); #1;
    rst = 1'b0; enable = 1'b1;

    // 1: basic scan, two full frames plus
    loadc(16'h4321, 4'b0000, 1'b0);
    run(85);
    // 2: leading-zero suppression
    loadc(16'h0050, 4'b0000, 1'b1);
    run(45);
    loadc(16'h0000, 4'b0000, 1'b1);
    run(45);
    loadc(16'h0000, 4'b0000, 1'b0);
    run(45);
    loadc(16'h0050, 4'b0000, 1'b0);
    run(45);
    // 3: decimal point on digit 2 only
    loadc(16'h4321, 4'b0100, 1'b0);
    run(45);
    // 4: load mid-slot of digit 1 (edge 16 of the frame)
    loadc(16'h4321, 4'b0000, 1'b0);
    while (e % 40 != 15) cycle();
    loadc(16'h9999, 4'b0000, 1'b0);
    run(40);
    // 5a: enable drops at cycle 3 of digit 2's slot, then resumes from digit 0
    loadc(16'h4321, 4'b0000, 1'b0);
    while (e % 40 != 24) cycle();
    enable = 1'b0;
    run(5);
    enable = 1'b1;
    run(30);
    // 5b: reset asserted mid-slot takes effect without a clock edge
    while (e % 10 != 4) cycle();
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_an",  8'(an),      8'hf);
    chk("midrst_bcd", 8'(bcd_out), 8'h0);
    chk("midrst_dp",  8'(dp_out),  8'h1);
    @(posedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b0;
    model_reset();
    run(45);

    @(negedge clk); #1;
    chk("queue_drained", 8'(q.size()), 8'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
